aes_inv_mix_column_seq: RTL
===========================

// Module: aes_inv_mix_column_seq
// PURPOSE
//  Iterative AES InvMixColumns unit: the decrypt-side counterpart of the
//  combinational forward MixColumns stage. It accepts a 128-bit state over a
//  valid/ready handshake and processes COLS_PER_CYCLE 32-bit columns per cycle
//  using GF(2^8) multiply-by-{0e,0b,0d,09}. It returns the result over a
//  valid/ready handshake. It sits in the decrypt round datapath between
//  AddRoundKey and InvShiftRows.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per BUSY cycle; legal values 1, 2, 4
//                     (elaboration error otherwise); N_BUSY = 4/COLS_PER_CYCLE
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    in_block is valid
//  in_ready   out  1    unit can accept a block
//  in_block   in   128  state input
//  out_valid  out  1    out_block holds a finished result
//  out_ready  in   1    downstream accepts out_block
//  out_block  out  128  state output
// BEHAVIOUR
//  Layout: column c occupies block[127-32c -: 32], for c = 0..3.
//   Row 0 is the MSB byte of each column. This matches the forward stage.
//  Per column (a0..a3 -> b0..b3), with xtime reduction polynomial 0x11B:
//   b0=0e*a0^0b*a1^0d*a2^09*a3   b1=09*a0^0e*a1^0b*a2^0d*a3
//   b2=0d*a0^09*a1^0e*a2^0b*a3   b3=0b*a0^0d*a1^09*a2^0e*a3
//  FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
//   IDLE: in_ready=1.
//    - On in_valid: latch in_block into the work register, clear col_cnt,
//      go to BUSY.
//   BUSY: in_ready=0.
//    - Each cycle, transform columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 in
//      place, then col_cnt += COLS_PER_CYCLE.
//    - After N_BUSY cycles (the last column group), go to DONE.
//   DONE: out_valid=1 and in_ready=0.
//    - When out_ready=1, go to IDLE (out_valid drops next cycle).
//  Latency: acceptance edge at t, then out_valid=1 after edge t+N_BUSY
//   (4, 2 or 1 cycles).
//  Throughput: one block per N_BUSY+2 cycles at best. Acceptance and the
//   output handshake never occur in the same cycle.
//  col_cnt: 2 bits. It wraps to 0 after the last group and is ignored outside
//   BUSY.
//  out_block: driven from the work register. It is stable for the whole time
//   out_valid=1. After the handshake it holds its last value until the next
//   acceptance overwrites it.
//  Inputs while not in IDLE: in_valid is ignored, in_block is not sampled and
//   no block is dropped silently; the producer must hold the block until
//   in_ready.
//  Back-pressure: out_ready=0 in DONE holds the state indefinitely.
//  Reset values (asynchronous, any state including mid-BUSY):
//   state=IDLE, in_ready=1 after reset, out_valid=0, out_block=128'h0,
//   col_cnt=0. The in-flight block is discarded.
//  out_ready outside DONE: no effect.
// TESTING
//  1. Reset then idle: after reset, in_ready=1, out_valid=0, out_block=0.
//  2. Known vector, COLS_PER_CYCLE=1:
//     in_block=8e4da1bc_9fdc589d_01010101_c6c6c6c6
//     -> out_block=db135345_f20a225c_01010101_c6c6c6c6, with out_valid
//     4 cycles after acceptance.
//  3. Second vector, COLS_PER_CYCLE=4:
//     in_block=d5d5d7d6_4d7ebdf8_00000000_ffffffff
//     -> out_block=d4d4d4d5_2d26314c_00000000_ffffffff, 1 cycle latency.
//  4. Back-pressure: hold out_ready=0 for 10 cycles in DONE
//     -> out_valid stays 1, out_block is unchanged, in_ready=0 and a new
//     in_valid is not accepted.
//  5. Reset mid-BUSY: assert rst_n=0 on the 2nd BUSY cycle
//     (COLS_PER_CYCLE=1) -> out_valid=0 and out_block=0 immediately; the next
//     block is processed correctly.
//  6. Round trip: 1000 random blocks through a forward MixColumns model and
//     then the DUT -> out_block == original, for all COLS_PER_CYCLE values.

Source files
------------

// File: rtl/aes_inv_mix_column_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_mix_column_seq
// Brief    : Iterative AES InvMixColumns, COLS_PER_CYCLE columns per cycle,
//            valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_mix_column_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block
);

    // col_cnt is 2 bits, so a step of 4 wraps to 0 and the only group is 0
    localparam logic [1:0] c_step     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] c_last_grp = 2'(4 - COLS_PER_CYCLE);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
        $error("aes_inv_mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_col_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_work     [4];
    logic [31:0] w_work_nxt [4];
    logic [31:0] w_col_out  [COLS_PER_CYCLE];
    logic [1:0]  w_col_idx  [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9, b, d, e built from the shared 2x/4x/8x chain of each byte
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign w_col_idx[k] = r_col_cnt + 2'(k);
        assign w_col_out[k] = inv_mix_col(r_work[w_col_idx[k]]);
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_work_nxt[c] = r_work[c];
        end
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            w_work_nxt[w_col_idx[k]] = w_col_out[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_col_cnt   <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                r_work[c] <= 32'h0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work[0]  <= in_block[127:96];
                        r_work[1]  <= in_block[95:64];
                        r_work[2]  <= in_block[63:32];
                        r_work[3]  <= in_block[31:0];
                        r_col_cnt  <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int c = 0; c < 4; c++) begin
                        r_work[c] <= w_work_nxt[c];
                    end
                    r_col_cnt <= r_col_cnt + c_step;
                    if (r_col_cnt == c_last_grp) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_block = {r_work[0], r_work[1], r_work[2], r_work[3]};

endmodule
`default_nettype wire
